// File: rtl/fp_accumulator.sv
// fp_accumulator
// Multi-cycle IEEE-754 single-precision accumulator for the dot-product
// datapath. It sums the multiplier's product stream into an internal
// accumulator and emits one sum per vector. A vector ends with the term
// that arrives with last_i set. Rounding is truncation toward zero, and
// denormal inputs are flushed to zero.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset; drops any term in flight
//   data_i       term to accumulate
//   valid_i      data_i/last_i are valid
//   last_i       this term closes the current vector
//   ready_o      a term can be accepted this cycle (high only in IDLE)
//   sum_o        completed vector sum; held until the next sum
//   sum_count_o  number of terms in sum_o; saturates at all-ones
//   sum_valid_o  one-cycle pulse marking a new sum_o/sum_count_o
module fp_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic [CNT_WIDTH-1:0]  sum_count_o,
  output logic                  sum_valid_o
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    WRITE
  } stateType;

  stateType state;
  stateType nextState;

  // Captured term and running accumulation
  logic [DATA_WIDTH-1:0] term;
  logic                  termLast;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]  count;

  // Aligned operands: X has the larger magnitude, Y is already shifted
  logic        xSign;
  logic        ySign;
  logic [7:0]  xExp;
  logic [23:0] xMant;
  logic [23:0] yMant;

  // Raw sum being normalised. The exponent has a spare bit so that
  // overflow past 254 can be detected in WRITE.
  logic        resSign;
  logic [8:0]  resExp;
  logic [24:0] resMant;

  // Registered sum outputs
  logic [DATA_WIDTH-1:0] sumReg;
  logic [CNT_WIDTH-1:0]  sumCount;
  logic                  sumValid;

  // Alignment helpers
  logic [7:0]  accExp;
  logic [7:0]  termExp;
  logic [7:0]  expDiff;
  logic [23:0] accMant;
  logic [23:0] termMant;
  logic [23:0] smallMant;
  logic [23:0] shiftedMant;
  logic        accIsX;

  // Datapath helpers
  logic [24:0]          addSum;
  logic                 normFinished;
  logic [DATA_WIDTH-1:0] writeAcc;
  logic [CNT_WIDTH-1:0]  writeCount;

  assign ready_o     = (state == IDLE);
  assign sum_o       = sumReg;
  assign sum_count_o = sumCount;
  assign sum_valid_o = sumValid;

  // Operand ordering and alignment. An exponent field of zero means the
  // value is zero, so the mantissa is dropped entirely; this is how
  // denormals are flushed. When the exponents are equal, the operand with
  // the larger mantissa becomes X. This keeps X-Y non-negative.
  always_comb begin
    accExp   = acc[30:23];
    termExp  = term[30:23];
    accMant  = (accExp != 8'd0) ? {1'b1, acc[22:0]} : 24'd0;
    termMant = (termExp != 8'd0) ? {1'b1, term[22:0]} : 24'd0;
    accIsX   = (accExp > termExp) || ((accExp == termExp) && (accMant >= termMant));
    if (accIsX) begin
      expDiff   = accExp - termExp;
      smallMant = termMant;
    end else begin
      expDiff   = termExp - accExp;
      smallMant = accMant;
    end
    shiftedMant = (expDiff >= 8'd24) ? 24'd0 : (smallMant >> expDiff);
  end

  // Magnitude add or subtract, plus the WRITE-stage results
  always_comb begin
    if (xSign == ySign) begin
      addSum = {1'b0, xMant} + {1'b0, yMant};
    end else begin
      addSum = {1'b0, xMant} - {1'b0, yMant};
    end
    // NORM ends on zero, on a carry out, on an already-normal result, or
    // when the next left shift would drive the exponent to zero.
    normFinished = (resMant == 25'd0) || resMant[24] || resMant[23] || (resExp == 9'd1);
    if (resExp >= 9'd255) begin
      writeAcc = {resSign, 8'hFF, 23'd0};
    end else begin
      writeAcc = {resSign, resExp[7:0], resMant[22:0]};
    end
    writeCount = (&count) ? count : count + CNT_WIDTH'(1);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (valid_i) nextState = ALIGN;
      ALIGN:   nextState = ADD;
      ADD:     nextState = NORM;
      NORM:    if (normFinished) nextState = WRITE;
      WRITE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath registers, advanced one stage per state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      term     <= '0;
      termLast <= 1'b0;
      acc      <= '0;
      count    <= '0;
      xSign    <= 1'b0;
      ySign    <= 1'b0;
      xExp     <= '0;
      xMant    <= '0;
      yMant    <= '0;
      resSign  <= 1'b0;
      resExp   <= '0;
      resMant  <= '0;
      sumReg   <= '0;
      sumCount <= '0;
      sumValid <= 1'b0;
    end else begin
      sumValid <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            term     <= data_i;
            termLast <= last_i;
          end
        end
        ALIGN: begin
          xSign <= accIsX ? acc[31] : term[31];
          ySign <= accIsX ? term[31] : acc[31];
          xExp  <= accIsX ? accExp : termExp;
          xMant <= accIsX ? accMant : termMant;
          yMant <= shiftedMant;
        end
        ADD: begin
          resSign <= xSign;
          resExp  <= {1'b0, xExp};
          resMant <= addSum;
        end
        NORM: begin
          if (resMant == 25'd0) begin
            resSign <= 1'b0;
            resExp  <= '0;
          end else if (resMant[24]) begin
            resMant <= resMant >> 1;
            resExp  <= resExp + 9'd1;
          end else if (!resMant[23]) begin
            // An exponent that would reach zero is treated as underflow to +0
            if (resExp == 9'd1) begin
              resSign <= 1'b0;
              resExp  <= '0;
              resMant <= '0;
            end else begin
              resMant <= resMant << 1;
              resExp  <= resExp - 9'd1;
            end
          end
        end
        WRITE: begin
          if (termLast) begin
            sumReg   <= writeAcc;
            sumCount <= writeCount;
            sumValid <= 1'b1;
            acc      <= '0;
            count    <= '0;
          end else begin
            acc   <= writeAcc;
            count <= writeCount;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
